// File: rtl/count_seq_pkg.sv
// Shared types and constants for the counter sequencer.
package count_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CLR  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_UP     = 2'b00;
   localparam logic [1:0] MODE_DOWN   = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;
   localparam logic [1:0] MODE_STEP   = 2'b11;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/count_sequencer_prescaler.sv
// Divides clkin into a terminal-count pulse every DIV enabled cycles.
module tick_prescaler #(
   parameter int DIV = 25000000
) (
   input  logic clkin,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] TC_VAL = PW'(DIV - 1);

   logic [PW-1:0] cnt_q, cnt_d;

   // Wraps at DIV-1, so the counter never needs a bit beyond clog2(DIV).
   always_comb begin
      tc    = enable && (cnt_q == TC_VAL);
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable)
         cnt_d = tc ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clkin) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/count_sequencer.sv
// Sequences the up/down counter datapath: prescaled ticks, direction per mode, clear on mode change.
module count_sequencer
   import count_seq_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DIV   = 25000000
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic             run,
   input  logic [1:0]       mode,
   input  logic             step,
   input  logic [WIDTH-1:0] cnt_val,
   output logic             cnt_en,
   output logic             cnt_dir,
   output logic             cnt_clr,
   output logic             tick,
   output logic             busy
);

   state_t     state_q, state_d;
   logic       dir_q, dir_d;
   logic       step_q, step_d;
   logic [1:0] mode_q, mode_d;
   logic       cnt_en_q, cnt_en_d;
   logic       cnt_dir_q, cnt_dir_d;
   logic       cnt_clr_q, cnt_clr_d;
   logic       tick_q, tick_d;
   logic       busy_q, busy_d;

   logic       mode_chg;
   logic       pre_en;
   logic       pre_tc;
   logic       bounce_dir;

   assign mode_chg = (mode != mode_q);
   // Prescaler only advances while we will stay in RUN; any exit clears it.
   assign pre_en   = (state_q == RUN) && run && !mode_chg;

   tick_prescaler #(.DIV(DIV)) u_pre (
      .clkin  (clkin),
      .reset  (reset),
      .clear  (!pre_en),
      .enable (pre_en),
      .tc     (pre_tc)
   );

   always_comb begin
      bounce_dir = dir_q;
      if (cnt_val == '1)
         bounce_dir = DIR_DOWN;
      else if (cnt_val == '0)
         bounce_dir = DIR_UP;

      state_d   = state_q;
      dir_d     = dir_q;
      step_d    = step;
      mode_d    = mode_q;
      cnt_en_d  = 1'b0;
      cnt_dir_d = cnt_dir_q;
      tick_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (mode_chg)
               state_d = CLR;
            else if (mode == MODE_STEP) begin
               if (step && !step_q) begin
                  cnt_en_d  = 1'b1;
                  cnt_dir_d = DIR_UP;
               end
            end else if (run)
               state_d = RUN;
         end
         RUN: begin
            if (mode_chg)
               state_d = CLR;
            else if (!run)
               state_d = IDLE;
            else if (pre_tc) begin
               tick_d   = 1'b1;
               cnt_en_d = 1'b1;
               case (mode_q)
                  MODE_UP:   cnt_dir_d = DIR_UP;
                  MODE_DOWN: cnt_dir_d = DIR_DOWN;
                  default: begin
                     cnt_dir_d = bounce_dir;
                     dir_d     = bounce_dir;
                  end
               endcase
            end
         end
         CLR: begin
            mode_d  = mode;
            dir_d   = (mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
            state_d = (run && mode != MODE_STEP) ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase

      cnt_clr_d = (state_d == CLR);
      busy_d    = (state_d == RUN);
   end

   always_ff @(posedge clkin) begin
      if (!reset) begin
         state_q   <= IDLE;
         dir_q     <= DIR_UP;
         step_q    <= 1'b1;
         mode_q    <= mode;
         cnt_en_q  <= 1'b0;
         cnt_dir_q <= DIR_UP;
         cnt_clr_q <= 1'b1;
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         step_q    <= step_d;
         mode_q    <= mode_d;
         cnt_en_q  <= cnt_en_d;
         cnt_dir_q <= cnt_dir_d;
         cnt_clr_q <= cnt_clr_d;
         tick_q    <= tick_d;
         busy_q    <= busy_d;
      end
   end

   assign cnt_en  = cnt_en_q;
   assign cnt_dir = cnt_dir_q;
   assign cnt_clr = cnt_clr_q;
   assign tick    = tick_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural counter datapath on cnt_val.
module tb_count_sequencer;
   import count_seq_pkg::*;

   localparam int W = 3;
   localparam int D = 4;

   logic         clkin = 1'b0;
   logic         reset = 1'b0;
   logic         run   = 1'b0;
   logic         step  = 1'b0;
   logic [1:0]   mode  = MODE_UP;
   logic [W-1:0] cnt_m = '0;
   logic         cnt_en, cnt_dir, cnt_clr, tick, busy;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] bval [0:14];
   logic [W-1:0] dval [0:2];
   logic [15:1]  bdir = 15'b1_0000000_1111111;

   count_sequencer #(.WIDTH(W), .DIV(D)) dut (
      .clkin   (clkin),
      .reset   (reset),
      .run     (run),
      .mode    (mode),
      .step    (step),
      .cnt_val (cnt_m),
      .cnt_en  (cnt_en),
      .cnt_dir (cnt_dir),
      .cnt_clr (cnt_clr),
      .tick    (tick),
      .busy    (busy)
   );

   always #5 clkin = ~clkin;

   always @(posedge clkin) begin
      if (cnt_clr)
         cnt_m <= '0;
      else if (cnt_en)
         cnt_m <= cnt_dir ? cnt_m + 1'b1 : cnt_m - 1'b1;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clkin);
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   initial begin
      bval = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
               3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      dval = '{3'd0, 3'd7, 3'd6};

      // reset held three cycles
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk1("rst_clr", cnt_clr, 1'b1);
         chk1("rst_en", cnt_en, 1'b0);
         chk1("rst_busy", busy, 1'b0);
         chk1("rst_tick", tick, 1'b0);
         chk1("rst_dir", cnt_dir, 1'b1);
      end
      reset = 1'b1;
      cyc(1);
      chk1("rel_clr", cnt_clr, 1'b0);
      chk1("rel_busy", busy, 1'b0);
      chk1("rel_en", cnt_en, 1'b0);

      // wrap-up counting
      run = 1'b1;
      cyc(1);
      chk1("up_busy", busy, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         cyc(3);
         chk1("up_quiet", cnt_en, 1'b0);
         chkv("up_val", cnt_m, W'(i - 1));
         cyc(1);
         chk1("up_en", cnt_en, 1'b1);
         chk1("up_tick", tick, 1'b1);
         chk1("up_dir", cnt_dir, 1'b1);
      end

      // switch to bounce: one clear cycle, then back to RUN
      mode = MODE_BOUNCE;
      cyc(1);
      chk1("b_clr", cnt_clr, 1'b1);
      chk1("b_clr_busy", busy, 1'b0);
      chk1("b_clr_en", cnt_en, 1'b0);
      chkv("up_wrap", cnt_m, W'(0));
      cyc(1);
      chk1("b_clr_off", cnt_clr, 1'b0);
      chk1("b_busy", busy, 1'b1);
      for (int i = 1; i <= 15; i++) begin
         cyc(3);
         chk1("b_quiet", cnt_en, 1'b0);
         chkv("b_val", cnt_m, bval[i-1]);
         cyc(1);
         chk1("b_en", cnt_en, 1'b1);
         chk1("b_dir", cnt_dir, bdir[i]);
      end

      // stop with prescaler at 2, then restart
      cyc(2);
      run = 1'b0;
      cyc(1);
      chk1("stop_busy", busy, 1'b0);
      chk1("stop_en", cnt_en, 1'b0);
      cyc(1);
      chk1("stop_en2", cnt_en, 1'b0);
      chk1("stop_tick", tick, 1'b0);
      cyc(1);
      run = 1'b1;
      cyc(1);
      chk1("re_busy", busy, 1'b1);
      chkv("re_val", cnt_m, W'(1));
      cyc(3);
      chk1("re_quiet", cnt_en, 1'b0);
      cyc(1);
      chk1("re_en", cnt_en, 1'b1);
      chk1("re_dir", cnt_dir, 1'b1);

      // single-step mode; run stays high and must not matter
      mode = MODE_STEP;
      cyc(1);
      chk1("s_clr", cnt_clr, 1'b1);
      chk1("s_clr_en", cnt_en, 1'b0);
      cyc(1);
      chk1("s_clr_off", cnt_clr, 1'b0);
      chk1("s_busy", busy, 1'b0);
      chkv("s_val0", cnt_m, W'(0));
      step = 1'b1;
      cyc(1);
      chk1("s_en1", cnt_en, 1'b1);
      chk1("s_dir1", cnt_dir, 1'b1);
      for (int i = 0; i < 9; i++) begin
         cyc(1);
         chk1("s_hold_en", cnt_en, 1'b0);
         chk1("s_hold_busy", busy, 1'b0);
      end
      step = 1'b0;
      cyc(2);
      chk1("s_low_en", cnt_en, 1'b0);
      step = 1'b1;
      cyc(1);
      chk1("s_en2", cnt_en, 1'b1);
      chk1("s_dir2", cnt_dir, 1'b1);
      cyc(1);
      chk1("s_after_en", cnt_en, 1'b0);
      chkv("s_val2", cnt_m, W'(2));

      // run up to 5, then change to wrap-down with a coincident step edge
      step = 1'b0;
      mode = MODE_UP;
      cyc(1);
      chk1("m_clr", cnt_clr, 1'b1);
      cyc(1);
      chk1("m_busy", busy, 1'b1);
      chkv("m_val0", cnt_m, W'(0));
      for (int i = 1; i <= 5; i++) begin
         cyc(3);
         chk1("m_quiet", cnt_en, 1'b0);
         chkv("m_val", cnt_m, W'(i - 1));
         cyc(1);
         chk1("m_en", cnt_en, 1'b1);
         chk1("m_dir", cnt_dir, 1'b1);
      end
      cyc(1);
      chkv("m_val5", cnt_m, W'(5));
      mode = MODE_DOWN;
      step = 1'b1;
      cyc(1);
      chk1("d_clr", cnt_clr, 1'b1);
      chk1("d_clr_en", cnt_en, 1'b0);
      chk1("d_clr_busy", busy, 1'b0);
      cyc(1);
      chk1("d_clr_off", cnt_clr, 1'b0);
      chk1("d_step_en", cnt_en, 1'b0);
      chk1("d_busy", busy, 1'b1);
      chkv("d_val0", cnt_m, W'(0));
      for (int i = 1; i <= 3; i++) begin
         cyc(3);
         chk1("d_quiet", cnt_en, 1'b0);
         chkv("d_val", cnt_m, dval[i-1]);
         cyc(1);
         chk1("d_en", cnt_en, 1'b1);
         chk1("d_tick", tick, 1'b1);
         chk1("d_dir", cnt_dir, 1'b0);
      end
      cyc(1);
      chkv("d_val5", cnt_m, W'(5));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Controller that sequences the board's small up/down counter datapath from the 50 MHz board clock. It prescales clkin into a counting tick and selects direction per a mode input: wrap-up, wrap-down, bounce (ping-pong) or manual single-step. It drives the counter's enable, direction and clear strobes, and reads the counter value back to decide bounce turnarounds. It replaces ad-hoc derived clocks: the whole counter path runs on clkin with enables.

Parameters:
WIDTH, 3, counter datapath width; the maximum count is all-ones.
DIV, 25000000, clkin cycles per counting tick. Legal range is 2 or more.

Ports:
clkin  in  1  board clock; all logic on its rising edge
reset  in  1  synchronous reset, active-low
run  in  1  level; 1 = free-running counting enabled (modes 00/01/10)
mode  in  2  00 wrap-up, 01 wrap-down, 10 bounce, 11 single-step
step  in  1  step request, already debounced and synchronised; acted on at its rising edge
cnt_val  in  WIDTH  current counter value returned from the datapath
cnt_en  out  1  one-cycle pulse: counter moves one position
cnt_dir  out  1  1 = up, 0 = down; valid whenever cnt_en=1
cnt_clr  out  1  one-cycle pulse: counter loads 0
tick  out  1  one-cycle pulse at each prescaler terminal count
busy  out  1  1 when state is RUN

Behaviour:
- Reset (reset=0 sampled at a clkin edge):
  - Register values: state=IDLE, prescaler=0, dir=1, step_q=1, mode_q=mode.
  - Outputs: cnt_en=0, tick=0, busy=0, cnt_dir=1, cnt_clr=1.
  - cnt_clr stays 1 for every reset cycle and drops in the first cycle after release.
  - Reset dominates every other input.
- All outputs are registered; no combinational input-to-output paths.
- States: IDLE, RUN, CLR.
  - IDLE: prescaler held at 0.
    - Go to RUN when run=1 and mode!=11.
    - When mode=11 and a step rising edge is seen (step=1, step_q=0): cnt_en=1 and cnt_dir=1 in the next cycle; stay in IDLE.
  - RUN: prescaler counts 0..DIV-1 and wraps.
    - At DIV-1: tick=1 and cnt_en=1 in the next cycle, with cnt_dir set as below.
    - run=0: go to IDLE next cycle, prescaler cleared, no pulse issued. A terminal count in that same cycle is dropped.
  - CLR (one cycle):
    - Entered from IDLE or RUN whenever mode!=mode_q.
    - Outputs: cnt_clr=1, prescaler=0, mode_q<=mode.
    - dir is set to 0 for mode 01, otherwise 1.
    - Next state is RUN if run=1 and mode!=11, else IDLE.
    - A mode change has priority over run and step in the same cycle; a step edge coinciding with a mode change is discarded.
- Direction per tick:
  - Mode 00: cnt_dir=1; the datapath wraps all-ones to 0.
  - Mode 01: cnt_dir=0; the datapath wraps 0 to all-ones.
  - Mode 10: new dir = 0 if cnt_val==all-ones, 1 if cnt_val==0, else unchanged. cnt_dir = new dir, and dir is updated. This gives 0,1..7,6..0,1 for WIDTH=3, never wrapping.
- step is ignored in modes 00/01/10. run is ignored in mode 11.
- step_q is updated every cycle, so a step held high produces exactly one pulse.
- Datapath contract:
  - The counter updates on the clkin edge where cnt_en=1, or clears where cnt_clr=1.
  - cnt_val reflects that update by the following cycle. DIV>=2 guarantees cnt_val is settled at the next terminal count.
- Latency: cnt_en follows the terminal-count cycle or step-edge cycle by exactly 1 clkin cycle. Tick period is DIV cycles.
- Prescaler width is clog2(DIV) bits. It counts up, compares against DIV-1, and must never overflow.

Decomposition:
- Package count_seq_pkg holds:
  - state enum (IDLE, RUN, CLR);
  - mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_BOUNCE=2'b10, MODE_STEP=2'b11;
  - DIR_UP=1, DIR_DOWN=0.
- One sub-module, tick_prescaler:
  - parameter DIV; inputs clkin, reset, clear, enable; output terminal-count pulse.
  - The FSM and direction logic stay in count_sequencer.

Test Plan:
- Reset: reset=0 for 3 cycles, then released -> cnt_clr=1 during reset, 0 in the first cycle after; cnt_en=0 and busy=0 throughout.
- Up count: DIV=4, mode=00, run=1 from IDLE -> busy=1; tick and cnt_en pulses every 4 cycles, cnt_dir=1. A model counter reads 1,2,..,7,0.
- Bounce: DIV=4, mode=10, model counter from 0 -> values 1..7, then 6..0, then 1. cnt_dir goes 0 on the pulse issued at cnt_val=7 and 1 on the pulse at cnt_val=0.
- Stop and restart: run dropped in RUN at prescaler=2 -> no cnt_en, next state IDLE. run=1 again -> first pulse occurs 4 cycles after re-entering RUN.
- Single-step: mode=11, step held high for 10 cycles, then low, then high -> exactly two cnt_en pulses with cnt_dir=1, each 1 cycle after the rising edge. run=1 has no effect.
- Mode change mid-run: mode 00 to 01 while RUN at count 5 -> one-cycle cnt_clr, counter=0. Next pulses have cnt_dir=0: 7,6,5. A step edge in the change cycle produces no pulse.
